// File: rtl/event_unit_pkg.sv
// Shared types and sizing for the event-unit interrupt delivery path.
package event_unit_pkg;

  localparam int EU_NUM_LINES = 32;
  localparam int EU_ID_WIDTH  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } sched_state_e;

endpackage

// File: rtl/irq_rr_picker.sv
// Masked priority encoder: lowest set index, optionally searching from a start
// pointer first and wrapping to the lowest set index overall.
module irq_rr_picker #(
  parameter int NUM_LINES = 32,
  parameter int ID_WIDTH  = 5
) (
  input  logic [NUM_LINES-1:0] vec,
  input  logic [ID_WIDTH-1:0]  start,
  input  logic                 mode,
  output logic                 valid,
  output logic [ID_WIDTH-1:0]  index
);

  logic                hi_valid;
  logic [ID_WIDTH-1:0] hi_idx;
  logic [ID_WIDTH-1:0] lo_idx;

  // Scan downwards so the last hit is the lowest index in each search window.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lo_idx = ID_WIDTH'(i);
        if (i >= int'(start)) begin
          hi_valid = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
      end
    end
  end

  assign valid = |vec;
  assign index = (mode && hi_valid) ? hi_idx : lo_idx;

endmodule

// File: rtl/irq_delivery_scheduler.sv
// Picks one pending interrupt line, hands it to the core as req/id, and after the
// core's ack pulses a one-hot clear followed by a hold-off window.
module irq_delivery_scheduler
  import event_unit_pkg::*;
#(
  parameter int NUM_LINES      = EU_NUM_LINES,
  parameter int ID_WIDTH       = EU_ID_WIDTH,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int ROUND_ROBIN    = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 sched_en_i,
  input  logic [NUM_LINES-1:0] pending_i,
  output logic                 core_irq_req_o,
  output logic [ID_WIDTH-1:0]  core_irq_id_o,
  input  logic                 core_irq_ack_i,
  input  logic [ID_WIDTH-1:0]  core_irq_ack_id_i,
  output logic [NUM_LINES-1:0] clear_pending_o,
  output logic                 ack_err_o,
  output logic                 busy_o
);

  localparam logic       RR_MODE   = (ROUND_ROBIN != 0);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES);

  sched_state_e         state;
  logic [ID_WIDTH-1:0]  id_q;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [3:0]           hold_cnt;

  logic                 pick_valid;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic [ID_WIDTH-1:0]  rr_next;
  logic [NUM_LINES-1:0] id_onehot;
  logic                 ack_match;

  irq_rr_picker #(
    .NUM_LINES (NUM_LINES),
    .ID_WIDTH  (ID_WIDTH)
  ) u_picker (
    .vec   (pending_i),
    .start (rr_ptr),
    .mode  (RR_MODE),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign rr_next   = (id_q == ID_WIDTH'(NUM_LINES - 1)) ? '0 : id_q + 1'b1;
  assign ack_match = core_irq_ack_i && (core_irq_ack_id_i == id_q);

  always_comb begin
    id_onehot       = '0;
    id_onehot[id_q] = 1'b1;
  end

  // id_q doubles as the registered id output; it is only meaningful while req is high.
  assign core_irq_id_o = id_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= IDLE;
      id_q            <= '0;
      rr_ptr          <= '0;
      hold_cnt        <= '0;
      core_irq_req_o  <= 1'b0;
      clear_pending_o <= '0;
      ack_err_o       <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      clear_pending_o <= '0;
      // A stray ack only raises the error flag; it never steers the FSM.
      ack_err_o       <= core_irq_ack_i && ((state != REQ) || !ack_match);

      unique case (state)
        IDLE: begin
          if (sched_en_i && pick_valid) begin
            id_q           <= pick_idx;
            core_irq_req_o <= 1'b1;
            busy_o         <= 1'b1;
            state          <= REQ;
          end
        end

        REQ: begin
          if (ack_match) begin
            core_irq_req_o  <= 1'b0;
            clear_pending_o <= id_onehot;
            state           <= CLEAR;
          end else if (!core_irq_ack_i && !pending_i[id_q]) begin
            // Line withdrawn by its source before the core took it.
            core_irq_req_o <= 1'b0;
            busy_o         <= 1'b0;
            state          <= IDLE;
          end
        end

        CLEAR: begin
          if (RR_MODE) rr_ptr <= rr_next;
          hold_cnt <= HOLD_LOAD;
          state    <= HOLDOFF;
        end

        HOLDOFF: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt <= 4'd1) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_delivery_scheduler.sv
// Two schedulers (fixed priority and round-robin) against a timestamp-based reference model.
module tb_irq_delivery_scheduler;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam int H  = 2;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;

  logic [1:0]         en;
  logic [1:0][N-1:0]  pend;
  logic [1:0]         ack;
  logic [1:0][IW-1:0] ack_id;
  logic [1:0]         req;
  logic [1:0][IW-1:0] id;
  logic [1:0][N-1:0]  clr;
  logic [1:0]         err;
  logic [1:0]         busy;

  always #5 HCLK = ~HCLK;

  irq_delivery_scheduler #(.NUM_LINES(N), .ID_WIDTH(IW), .HOLDOFF_CYCLES(H), .ROUND_ROBIN(0)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn), .sched_en_i(en[0]), .pending_i(pend[0]),
    .core_irq_req_o(req[0]), .core_irq_id_o(id[0]), .core_irq_ack_i(ack[0]),
    .core_irq_ack_id_i(ack_id[0]), .clear_pending_o(clr[0]), .ack_err_o(err[0]), .busy_o(busy[0]));

  irq_delivery_scheduler #(.NUM_LINES(N), .ID_WIDTH(IW), .HOLDOFF_CYCLES(H), .ROUND_ROBIN(1)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .sched_en_i(en[1]), .pending_i(pend[1]),
    .core_irq_req_o(req[1]), .core_irq_id_o(id[1]), .core_irq_ack_i(ack[1]),
    .core_irq_ack_id_i(ack_id[1]), .clear_pending_o(clr[1]), .ack_err_o(err[1]), .busy_o(busy[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: a request is either outstanding or not; after a served
  // interrupt the scheduler is unavailable until cycle idle_from.
  int cyc = 0;
  bit m_req  [2];
  int m_id   [2];
  int m_rr   [2];
  int m_clr  [2];
  bit m_err  [2];
  int idle_from [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_id[i] = 0; m_rr[i] = 0; m_clr[i] = -1; m_err[i] = 0;
      idle_from[i] = cyc;
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = ack[i] && !(m_req[i] && int'(ack_id[i]) == m_id[i]);
      m_clr[i] = -1;
      if (m_req[i]) begin
        if (ack[i] && int'(ack_id[i]) == m_id[i]) begin
          m_req[i] = 0;
          m_clr[i] = m_id[i];
          if (i == 1) m_rr[i] = (m_id[i] + 1) % N;
          idle_from[i] = cyc + 1 + H;
        end else if (!ack[i] && !pend[i][m_id[i]]) begin
          m_req[i] = 0;
          idle_from[i] = cyc;
        end
      end else if (cyc > idle_from[i] && en[i] && pend[i] != '0) begin
        m_req[i] = 1;
        m_id[i]  = pick(pend[i], (i == 1) ? m_rr[i] : 0);
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      string s;
      logic [N-1:0] exp_clr;
      s = (i == 1) ? "rr" : "fix";
      exp_clr = (m_clr[i] >= 0) ? (N'(1) << m_clr[i]) : '0;
      chk({s, ".req"}, 32'(req[i]), 32'(m_req[i]));
      if (m_req[i]) chk({s, ".id"}, 32'(id[i]), 32'(m_id[i]));
      chk({s, ".clr"}, 32'(clr[i]), 32'(exp_clr));
      chk({s, ".err"}, 32'(err[i]), 32'(m_err[i]));
      chk({s, ".busy"}, 32'(busy[i]), 32'(m_req[i] || cyc < idle_from[i]));
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
    compare();
  endtask

  task automatic check_reset(input string name);
    chk({name, ".req_busy_err"}, 32'({req, busy, err}), 32'h0);
    chk({name, ".id"}, 32'({id[1], id[0]}), 32'h0);
    chk({name, ".clr_fix"}, 32'(clr[0]), 32'h0);
    chk({name, ".clr_rr"}, 32'(clr[1]), 32'h0);
  endtask

  // Called just after a tick; reset lands mid-cycle and must clear outputs at once.
  task automatic do_reset(input string name);
    #1 HRESETn = 1'b0;
    #1 check_reset(name);
    model_reset();
    ack = '0;
    #10 HRESETn = 1'b1;
  endtask

  task automatic wait_req(input int i, input string name);
    int n;
    n = 0;
    while (!m_req[i] && n < 40) begin
      tick();
      n++;
    end
    if (!m_req[i]) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no request after %0d cycles", name, n);
    end
  endtask

  task automatic serve(input int i, input int exp_id, input string name);
    wait_req(i, name);
    chk({name, ".id"}, 32'(id[i]), 32'(exp_id));
    ack[i] = 1'b1;
    ack_id[i] = IW'(exp_id);
    tick();
    ack[i] = 1'b0;
    chk({name, ".clr"}, 32'(clr[i]), 32'(N'(1) << exp_id));
    pend[i][exp_id] = 1'b0;
  endtask

  initial begin
    en = '0; pend = '0; ack = '0; ack_id = '0;
    #1 HRESETn = 1'b0;
    #2 check_reset("por");
    model_reset();
    #9 HRESETn = 1'b1;

    // Fixed priority: 0x28 -> 3, then 5 after the hold-off.
    pend[0] = 32'h28; en[0] = 1'b1;
    tick();
    chk("A.req", 32'(req[0]), 32'd1);
    chk("A.id", 32'(id[0]), 32'd3);
    ack[0] = 1'b1; ack_id[0] = 5'd3;
    tick();
    ack[0] = 1'b0;
    chk("A.clr", 32'(clr[0]), 32'h8);
    chk("A.req_drop", 32'(req[0]), 32'd0);
    pend[0] = 32'h20;
    tick();
    chk("A.hold1", 32'(req[0]), 32'd0);
    chk("A.clr_once", 32'(clr[0]), 32'h0);
    tick();
    chk("A.hold2", 32'(req[0]), 32'd0);
    tick();
    tick();
    chk("A.req5", 32'(req[0]), 32'd1);
    chk("A.id5", 32'(id[0]), 32'd5);
    ack[0] = 1'b1; ack_id[0] = 5'd5;
    tick();
    ack[0] = 1'b0; pend[0] = '0; en[0] = 1'b0;
    repeat (4) tick();

    // Round-robin order 0, 1, 31, then pointer wraps to 0.
    pend[1] = 32'h8000_0003; en[1] = 1'b1;
    serve(1, 0, "B0");
    serve(1, 1, "B1");
    serve(1, 31, "B31");
    pend[1] = 32'h8000_0001;
    serve(1, 0, "Bwrap");
    serve(1, 31, "Bend");
    en[1] = 1'b0;
    repeat (4) tick();

    // Mismatched ack then matching ack.
    pend[0] = 32'h10; en[0] = 1'b1;
    wait_req(0, "C");
    chk("C.id", 32'(id[0]), 32'd4);
    ack[0] = 1'b1; ack_id[0] = 5'd7;
    tick();
    chk("C.err", 32'(err[0]), 32'd1);
    chk("C.req_hold", 32'(req[0]), 32'd1);
    chk("C.id_hold", 32'(id[0]), 32'd4);
    ack_id[0] = 5'd4;
    tick();
    ack[0] = 1'b0;
    chk("C.clr", 32'(clr[0]), 32'h10);
    pend[0] = '0;
    repeat (4) tick();

    // Withdrawal, then ack racing withdrawal.
    pend[0] = 32'h4;
    wait_req(0, "D");
    chk("D.id", 32'(id[0]), 32'd2);
    pend[0] = '0;
    tick();
    chk("D.req", 32'(req[0]), 32'd0);
    chk("D.clr", 32'(clr[0]), 32'h0);
    chk("D.busy", 32'(busy[0]), 32'd0);
    pend[0] = 32'h4;
    wait_req(0, "D2");
    ack[0] = 1'b1; ack_id[0] = 5'd2; pend[0] = '0;
    tick();
    ack[0] = 1'b0;
    chk("D2.clr", 32'(clr[0]), 32'h4);
    repeat (4) tick();

    // Disabled scheduler never requests; disabling mid-request doesn't abort.
    en[0] = 1'b0; pend[0] = '1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("E.noreq", 32'(req[0]), 32'd0);
    end
    en[0] = 1'b1;
    tick();
    chk("E.req", 32'(req[0]), 32'd1);
    chk("E.id", 32'(id[0]), 32'd0);
    en[0] = 1'b0;
    tick();
    chk("E.req_held", 32'(req[0]), 32'd1);
    ack[0] = 1'b1; ack_id[0] = 5'd0;
    tick();
    ack[0] = 1'b0;
    chk("E.clr", 32'(clr[0]), 32'h1);
    pend[0] = '0;
    repeat (4) tick();

    // Reset with fix in REQ and rr in HOLDOFF (rr pointer would be 8).
    pend[0] = 32'h1; en[0] = 1'b1;
    pend[1] = 32'h80; en[1] = 1'b1;
    wait_req(0, "F");
    chk("F.rr_id", 32'(id[1]), 32'd7);
    ack[1] = 1'b1; ack_id[1] = 5'd7;
    tick();
    ack[1] = 1'b0; pend[1] = '0;
    tick();
    do_reset("F.rst");
    pend[1] = 32'h101;
    tick();
    chk("F.fix_id", 32'(id[0]), 32'd0);
    chk("F.rr_id0", 32'(id[1]), 32'd0);
    chk("F.rr_req", 32'(req[1]), 32'd1);
    ack = 2'b11; ack_id = '0;
    tick();
    ack = '0;
    pend = '0; en = '0;
    repeat (5) tick();

    // Randomized traffic on both instances.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_clr[i] >= 0) pend[i][m_clr[i]] = 1'b0;
        en[i] = ($urandom % 8) != 0;
        if ($urandom % 4 == 0) pend[i][$urandom % N] = 1'b1;
        if ($urandom % 40 == 0) pend[i][$urandom % N] = 1'b0;
        if (m_req[i] && $urandom % 16 == 0) pend[i][m_id[i]] = 1'b0;
        if (m_req[i] && $urandom % 4 == 0) begin
          ack[i] = 1'b1;
          ack_id[i] = ($urandom % 8 == 0) ? IW'($urandom) : IW'(m_id[i]);
        end else if ($urandom % 20 == 0) begin
          ack[i] = 1'b1;
          ack_id[i] = IW'($urandom);
        end else begin
          ack[i] = 1'b0;
        end
      end
      tick();
      if ($urandom % 1500 == 0) do_reset("R.rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
